// File: rtl/beam_power_rank_if.sv
`default_nettype none
// ============================================================================
// Module      : beam_power_rank_if
// Description : Bundle of the beam-sum stream (from the beam MAC stage) and
//               the ranked-beam result (to dimension-reduction control).
//               master : drives i_sum_data / i_tvalid / i_nre, receives results
//               slave  : beam_power_rank side
//   i_sum_data   [BEAM-1:0][OW-1:0]          packed complex beam sums
//   i_tvalid     1                           beat valid, no backpressure
//   i_nre        NRE_W                       beats per window
//   o_beam_idx   [TOPK-1:0][$clog2(BEAM)-1:0] ranked indices, entry 0 strongest
//   o_beam_pwr   [TOPK-1:0][ACC_W-1:0]       accumulated power per rank
//   o_rank_valid 1                           one-cycle result pulse
//   o_busy       1                           block not idle
//   o_overflow   1                           sticky beat-dropped flag
//   Parameters must match those of the beam_power_rank instance it serves.
// Revision    : 1.0 - initial release
// ============================================================================
interface beam_power_rank_if #(
    parameter int BEAM  = 16,
    parameter int OW    = 32,
    parameter int ACC_W = 48,
    parameter int NRE_W = 12,
    parameter int TOPK  = 4
);
    localparam int c_IW = $clog2(BEAM);

    logic [BEAM-1:0][OW-1:0]    i_sum_data;
    logic                       i_tvalid;
    logic [NRE_W-1:0]           i_nre;
    logic [TOPK-1:0][c_IW-1:0]  o_beam_idx;
    logic [TOPK-1:0][ACC_W-1:0] o_beam_pwr;
    logic                       o_rank_valid;
    logic                       o_busy;
    logic                       o_overflow;

    modport master (
        output i_sum_data, i_tvalid, i_nre,
        input  o_beam_idx, o_beam_pwr, o_rank_valid, o_busy, o_overflow
    );

    modport slave (
        input  i_sum_data, i_tvalid, i_nre,
        output o_beam_idx, o_beam_pwr, o_rank_valid, o_busy, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/beam_power_rank.sv
`default_nettype none
// ============================================================================
// Module      : beam_power_rank
// Description : Accumulates |x|^2 of every beam over a window of i_nre valid
//               beats, then serially selects the TOPK strongest beams (ties go
//               to the lower index) and presents them with a one-cycle pulse.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : beam_power_rank_if.slave (sum stream in, ranking out)
//   Optional feature macro BEAM_RANK_SAT_EN: when defined the accumulators
//   saturate at 2^ACC_W-1, otherwise they wrap modulo 2^ACC_W.
//   Assumes BEAM >= 2, OW even, TOPK <= BEAM.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_power_rank #(
    parameter int BEAM  = 16,
    parameter int OW    = 32,
    parameter int ACC_W = 48,
    parameter int NRE_W = 12,
    parameter int TOPK  = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    beam_power_rank_if.slave   bus
);
    localparam int c_H  = OW / 2;
    localparam int c_H2 = 2 * c_H;
    localparam int c_PW = c_H2 + 1;
    localparam int c_SW = ((c_PW > ACC_W) ? c_PW : ACC_W) + 1;
    localparam int c_IW = $clog2(BEAM);
    localparam int c_RW = (TOPK > 1) ? $clog2(TOPK) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_DRAIN = 3'd2,
        S_SORT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                     state_q,      state_d;
    logic [NRE_W-1:0]           nre_q,        nre_d;
    logic [NRE_W-1:0]           cnt_q,        cnt_d;
    logic [BEAM-1:0][c_PW-1:0]  p_q,          p_d;
    logic                       pv_q,         pv_d;
    logic                       pfirst_q,     pfirst_d;
    logic [BEAM-1:0][ACC_W-1:0] acc_q,        acc_d;
    logic                       drain_q,      drain_d;
    logic [c_IW-1:0]            scan_q,       scan_d;
    logic [c_RW-1:0]            pass_q,       pass_d;
    logic [c_IW-1:0]            best_idx_q,   best_idx_d;
    logic [ACC_W-1:0]           best_pwr_q,   best_pwr_d;
    logic                       best_vld_q,   best_vld_d;
    logic [BEAM-1:0]            mask_q,       mask_d;
    logic [TOPK-1:0][c_IW-1:0]  rank_idx_q,   rank_idx_d;
    logic [TOPK-1:0][ACC_W-1:0] rank_pwr_q,   rank_pwr_d;
    logic [TOPK-1:0][c_IW-1:0]  out_idx_q,    out_idx_d;
    logic [TOPK-1:0][ACC_W-1:0] out_pwr_q,    out_pwr_d;
    logic                       rank_valid_q, rank_valid_d;
    logic                       busy_q,       busy_d;
    logic                       overflow_q,   overflow_d;

    logic [BEAM-1:0][c_PW-1:0]  w_p;
    logic [BEAM-1:0][ACC_W-1:0] w_acc_next;
    logic                       w_accept;
    logic [ACC_W-1:0]           w_cand;
    logic                       w_win;
    logic [c_IW-1:0]            w_sel_idx;
    logic [ACC_W-1:0]           w_sel_pwr;

    // Per-beam power and accumulator update
    for (genvar k = 0; k < BEAM; k++) begin : g_beam
        logic signed [c_H-1:0]  w_re;
        logic signed [c_H-1:0]  w_im;
        logic signed [c_H2-1:0] w_re_x;
        logic signed [c_H2-1:0] w_im_x;
        logic [c_H2-1:0]        w_re2;
        logic [c_H2-1:0]        w_im2;
        logic [c_SW-1:0]        w_pext;
        logic [c_SW-1:0]        w_base;

        assign w_re   = bus.i_sum_data[k][c_H-1:0];
        assign w_im   = bus.i_sum_data[k][c_H2-1:c_H];
        assign w_re_x = c_H2'(w_re);
        assign w_im_x = c_H2'(w_im);
        // Squares are never negative; the worst case (-2^(c_H-1))^2 still fits.
        assign w_re2  = w_re_x * w_re_x;
        assign w_im2  = w_im_x * w_im_x;
        assign w_p[k] = {1'b0, w_re2} + {1'b0, w_im2};

        // First beat of a window loads instead of adding to the stale value.
        assign w_pext = c_SW'(p_q[k]);
        assign w_base = pfirst_q ? '0 : c_SW'(acc_q[k]);

`ifdef BEAM_RANK_SAT_EN
        localparam logic [c_SW-1:0] c_LIM = {{(c_SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
        logic [c_SW-1:0] w_sum;
        assign w_sum = w_base + w_pext;
        assign w_acc_next[k] = (w_sum > c_LIM) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        assign w_acc_next[k] = ACC_W'(w_base + w_pext);
`endif
    end

    always_comb begin
        state_d      = state_q;
        nre_d        = nre_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        pv_d         = 1'b0;
        pfirst_d     = pfirst_q;
        acc_d        = acc_q;
        drain_d      = drain_q;
        scan_d       = scan_q;
        pass_d       = pass_q;
        best_idx_d   = best_idx_q;
        best_pwr_d   = best_pwr_q;
        best_vld_d   = best_vld_q;
        mask_d       = mask_q;
        rank_idx_d   = rank_idx_q;
        rank_pwr_d   = rank_pwr_q;
        out_idx_d    = out_idx_q;
        out_pwr_d    = out_pwr_q;
        rank_valid_d = 1'b0;
        overflow_d   = overflow_q;
        w_cand       = acc_q[scan_q];
        w_win        = 1'b0;
        w_sel_idx    = best_idx_q;
        w_sel_pwr    = best_pwr_q;

        w_accept = bus.i_tvalid && ((state_q == S_IDLE) || (state_q == S_ACC));

        // Stage 1: register the beat power
        if (w_accept) begin
            pv_d     = 1'b1;
            p_d      = w_p;
            pfirst_d = (state_q == S_IDLE);
        end

        // Stage 2: load/accumulate one cycle later
        if (pv_q) begin
            acc_d = w_acc_next;
        end

        // No backpressure: anything arriving outside IDLE/ACC is lost.
        if (bus.i_tvalid && !w_accept) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_tvalid) begin
                    nre_d = (bus.i_nre == '0) ? NRE_W'(1) : bus.i_nre;
                    cnt_d = NRE_W'(1);
                    if (bus.i_nre <= NRE_W'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (bus.i_tvalid) begin
                    cnt_d = cnt_q + NRE_W'(1);
                    if ((cnt_q + NRE_W'(1)) == nre_q) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles so the last beat has passed both pipeline stages.
                if (drain_q) begin
                    state_d    = S_SORT;
                    scan_d     = '0;
                    pass_d     = '0;
                    best_vld_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_SORT: begin
                // Strict compare while scanning upward keeps the lowest index
                // on ties; best_vld lets an all-zero beam still be selected.
                w_win = !mask_q[scan_q] && (!best_vld_q || (w_cand > best_pwr_q));
                if (scan_q == c_IW'(BEAM-1)) begin
                    if (w_win) begin
                        w_sel_idx = scan_q;
                        w_sel_pwr = w_cand;
                    end
                    rank_idx_d[pass_q] = w_sel_idx;
                    rank_pwr_d[pass_q] = w_sel_pwr;
                    mask_d[w_sel_idx]  = 1'b1;
                    best_vld_d         = 1'b0;
                    scan_d             = '0;
                    if (pass_q == c_RW'(TOPK-1)) begin
                        state_d = S_OUT;
                    end else begin
                        pass_d = pass_q + c_RW'(1);
                    end
                end else begin
                    if (w_win) begin
                        best_idx_d = scan_q;
                        best_pwr_d = w_cand;
                        best_vld_d = 1'b1;
                    end
                    scan_d = scan_q + c_IW'(1);
                end
            end
            S_OUT: begin
                out_idx_d    = rank_idx_q;
                out_pwr_d    = rank_pwr_q;
                rank_valid_d = 1'b1;
                mask_d       = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            nre_q        <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            pv_q         <= 1'b0;
            pfirst_q     <= 1'b0;
            acc_q        <= '0;
            drain_q      <= 1'b0;
            scan_q       <= '0;
            pass_q       <= '0;
            best_idx_q   <= '0;
            best_pwr_q   <= '0;
            best_vld_q   <= 1'b0;
            mask_q       <= '0;
            rank_idx_q   <= '0;
            rank_pwr_q   <= '0;
            out_idx_q    <= '0;
            out_pwr_q    <= '0;
            rank_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            nre_q        <= nre_d;
            cnt_q        <= cnt_d;
            p_q          <= p_d;
            pv_q         <= pv_d;
            pfirst_q     <= pfirst_d;
            acc_q        <= acc_d;
            drain_q      <= drain_d;
            scan_q       <= scan_d;
            pass_q       <= pass_d;
            best_idx_q   <= best_idx_d;
            best_pwr_q   <= best_pwr_d;
            best_vld_q   <= best_vld_d;
            mask_q       <= mask_d;
            rank_idx_q   <= rank_idx_d;
            rank_pwr_q   <= rank_pwr_d;
            out_idx_q    <= out_idx_d;
            out_pwr_q    <= out_pwr_d;
            rank_valid_q <= rank_valid_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.o_beam_idx   = out_idx_q;
    assign bus.o_beam_pwr   = out_pwr_q;
    assign bus.o_rank_valid = rank_valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_power_rank.sv
`default_nettype none
// ============================================================================
// Module      : tb_beam_power_rank
// Description : Directed bench for beam_power_rank (ACC_W=32 so that the
//               saturation/wrap case is reachable). A window-level model
//               predicts every output each cycle; literal expectations pin the
//               ranking results and result latency. Honours BEAM_RANK_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_power_rank;
    localparam int BEAM  = 16;
    localparam int OW    = 32;
    localparam int ACC_W = 32;
    localparam int NRE_W = 12;
    localparam int TOPK  = 4;
    localparam int IW    = $clog2(BEAM);
    localparam int LAT   = 3 + TOPK * BEAM;
    localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

    typedef logic [BEAM-1:0][OW-1:0] dvec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    beam_power_rank_if #(.BEAM(BEAM), .OW(OW), .ACC_W(ACC_W), .NRE_W(NRE_W), .TOPK(TOPK)) u_if ();

    beam_power_rank #(.BEAM(BEAM), .OW(OW), .ACC_W(ACC_W), .NRE_W(NRE_W), .TOPK(TOPK)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (window level) ----------------
    longint unsigned m_acc [BEAM];
    int              m_st  = 0;      // 0 idle, 1 collecting, 2 waiting for result
    int              m_cnt = 0;
    int              m_nre = 0;
    longint          m_now = 0;
    longint          m_due = -1;
    logic            m_rv   = 1'b0;
    logic            m_busy = 1'b0;
    logic            m_ovf  = 1'b0;
    int              m_idx  [TOPK];
    longint unsigned m_pwr  [TOPK];
    int              m_pidx [TOPK];
    longint unsigned m_ppwr [TOPK];

    function automatic longint unsigned beat_pwr(input logic [OW-1:0] w);
        logic signed [OW/2-1:0] re;
        logic signed [OW/2-1:0] im;
        longint r;
        longint i;
        re = w[OW/2-1:0];
        im = w[OW-1:OW/2];
        r  = re;
        i  = im;
        return longint'(r * r + i * i);
    endfunction

    function automatic longint unsigned acc_add(input longint unsigned a, input longint unsigned p);
        longint unsigned s;
        s = a + p;
`ifdef BEAM_RANK_SAT_EN
        return (s > MAXV) ? MAXV : s;
`else
        return s & MAXV;
`endif
    endfunction

    task automatic model_close();
        bit used [BEAM];
        for (int k = 0; k < BEAM; k++) used[k] = 1'b0;
        for (int r = 0; r < TOPK; r++) begin
            int best;
            best = -1;
            for (int k = 0; k < BEAM; k++) begin
                if (!used[k] && (best < 0 || m_acc[k] > m_acc[best])) best = k;
            end
            used[best] = 1'b1;
            m_pidx[r]  = best;
            m_ppwr[r]  = m_acc[best];
        end
        m_st  = 2;
        m_due = m_now + LAT;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_due = -1;
            m_rv = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
            for (int r = 0; r < TOPK; r++) begin m_idx[r] = 0; m_pwr[r] = 0; end
        end else begin
            m_now++;
            m_rv = 1'b0;
            if (u_if.i_tvalid) begin
                if (m_st == 0) begin
                    m_nre = (u_if.i_nre == 0) ? 1 : int'(u_if.i_nre);
                    for (int k = 0; k < BEAM; k++) m_acc[k] = acc_add(0, beat_pwr(u_if.i_sum_data[k]));
                    m_cnt  = 1;
                    m_busy = 1'b1;
                    m_st   = 1;
                    if (m_cnt == m_nre) model_close();
                end else if (m_st == 1) begin
                    for (int k = 0; k < BEAM; k++) m_acc[k] = acc_add(m_acc[k], beat_pwr(u_if.i_sum_data[k]));
                    m_cnt++;
                    if (m_cnt == m_nre) model_close();
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_now == m_due) begin
                for (int r = 0; r < TOPK; r++) begin m_idx[r] = m_pidx[r]; m_pwr[r] = m_ppwr[r]; end
                m_rv   = 1'b1;
                m_busy = 1'b0;
                m_st   = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("rank_valid", 64'(u_if.o_rank_valid), 64'(m_rv));
        check("busy",       64'(u_if.o_busy),       64'(m_busy));
        check("overflow",   64'(u_if.o_overflow),   64'(m_ovf));
        for (int r = 0; r < TOPK; r++) begin
            check($sformatf("beam_idx[%0d]", r), 64'(u_if.o_beam_idx[r]), 64'(m_idx[r]));
            check($sformatf("beam_pwr[%0d]", r), 64'(u_if.o_beam_pwr[r]), m_pwr[r]);
        end
    end

    // ---------------- result history ----------------
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                         rv_cnt = 0;
    logic [TOPK-1:0][IW-1:0]    h_idx [16];
    logic [TOPK-1:0][ACC_W-1:0] h_pwr [16];
    longint                     h_cyc [16];

    always @(negedge clk) begin
        if (rst_n && u_if.o_rank_valid && rv_cnt < 16) begin
            h_idx[rv_cnt] = u_if.o_beam_idx;
            h_pwr[rv_cnt] = u_if.o_beam_pwr;
            h_cyc[rv_cnt] = cyc;
            rv_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input dvec_t d, input logic [NRE_W-1:0] n);
        @(posedge clk);
        #1;
        u_if.i_tvalid   = v;
        u_if.i_sum_data = d;
        u_if.i_nre      = n;
    endtask

    function automatic dvec_t one_beam(input int k, input int re, input int im);
        dvec_t d;
        d = '0;
        d[k][OW/2-1:0]  = (OW/2)'(re);
        d[k][OW-1:OW/2] = (OW/2)'(im);
        return d;
    endfunction

    task automatic wait_rank();
        int  n0;
        bit  ok;
        n0 = rv_cnt;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (rv_cnt != n0) begin ok = 1'b1; break; end
        end
        check("rank_timeout", 64'(ok), 64'd1);
    endtask

    longint t_last;
    longint t0;
    int     base;
    dvec_t  d;

    initial begin
        u_if.i_tvalid   = 1'b0;
        u_if.i_sum_data = '0;
        u_if.i_nre      = '0;
        rst_n           = 1'b0;
        @(posedge clk);
        #1;
        check("reset_rank_valid", 64'(u_if.o_rank_valid), 64'd0);
        check("reset_busy",       64'(u_if.o_busy),       64'd0);
        check("reset_overflow",   64'(u_if.o_overflow),   64'd0);
        check("reset_pwr0",       64'(u_if.o_beam_pwr[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ordered ranking: beam k re=k, 4 beats
        for (int k = 0; k < BEAM; k++) d[k] = {16'h0000, 16'(k)};
        for (int i = 0; i < 4; i++) drive(1'b1, d, 12'd4);
        drive(1'b0, '0, '0);
        t_last = cyc;
        wait_rank();
        base = rv_cnt - 1;
        check("ord_idx0", 64'(h_idx[base][0]), 64'd15);
        check("ord_idx1", 64'(h_idx[base][1]), 64'd14);
        check("ord_idx2", 64'(h_idx[base][2]), 64'd13);
        check("ord_idx3", 64'(h_idx[base][3]), 64'd12);
        check("ord_pwr0", 64'(h_pwr[base][0]), 64'd900);
        check("ord_pwr1", 64'(h_pwr[base][1]), 64'd784);
        check("ord_pwr2", 64'(h_pwr[base][2]), 64'd676);
        check("ord_pwr3", 64'(h_pwr[base][3]), 64'd576);
        check("ord_latency", 64'(h_cyc[base] - t_last), 64'd67);

        // Tie break: all beams 3+4j, 2 beats
        for (int k = 0; k < BEAM; k++) d[k] = {16'd4, 16'd3};
        for (int i = 0; i < 2; i++) drive(1'b1, d, 12'd2);
        drive(1'b0, '0, '0);
        wait_rank();
        base = rv_cnt - 1;
        for (int r = 0; r < TOPK; r++) begin
            check($sformatf("tie_idx%0d", r), 64'(h_idx[base][r]), 64'(r));
            check($sformatf("tie_pwr%0d", r), 64'(h_pwr[base][r]), 64'd50);
        end

        // i_nre = 0 behaves as a one-beat window
        drive(1'b1, one_beam(2, 1, 0), 12'd0);
        drive(1'b0, '0, '0);
        t_last = cyc;
        wait_rank();
        base = rv_cnt - 1;
        check("nre0_idx0", 64'(h_idx[base][0]), 64'd2);
        check("nre0_pwr0", 64'(h_pwr[base][0]), 64'd1);
        check("nre0_latency", 64'(h_cyc[base] - t_last), 64'd67);

        // Continuous valid with one-beat windows: drops during drain/sort/out
        base = rv_cnt;
        for (int j = 0; j <= 68; j++) begin
            drive(1'b1, one_beam((j + 5) % BEAM, j + 3, 0), 12'd1);
            if (j == 1) begin
                t0 = cyc;
                check("drop_busy",   64'(u_if.o_busy),     64'd1);
                check("drop_ovf_lo", 64'(u_if.o_overflow), 64'd0);
            end
            if (j == 2) check("drop_ovf_hi", 64'(u_if.o_overflow), 64'd1);
        end
        drive(1'b0, '0, '0);
        wait_rank();
        check("drop_rank_count", 64'(rv_cnt - base), 64'd2);
        check("drop_first_idx0", 64'(h_idx[base][0]), 64'd5);
        check("drop_first_pwr0", 64'(h_pwr[base][0]), 64'd9);
        check("drop_first_idx1", 64'(h_idx[base][1]), 64'd0);
        check("drop_first_time", 64'(h_cyc[base] - t0), 64'd67);
        check("drop_next_idx0",  64'(h_idx[base+1][0]), 64'd9);
        check("drop_next_pwr0",  64'(h_pwr[base+1][0]), 64'd5041);
        check("drop_next_gap",   64'(h_cyc[base+1] - h_cyc[base]), 64'd68);

        // Saturation / wrap: beam 5 re=im=-32768 for 4095 beats
        for (int i = 0; i < 4095; i++) drive(1'b1, one_beam(5, -32768, -32768), 12'd4095);
        drive(1'b0, '0, '0);
        wait_rank();
        base = rv_cnt - 1;
        check("sat_idx0", 64'(h_idx[base][0]), 64'd5);
`ifdef BEAM_RANK_SAT_EN
        check("sat_pwr0", 64'(h_pwr[base][0]), 64'hFFFF_FFFF);
`else
        check("sat_pwr0", 64'(h_pwr[base][0]), 64'h8000_0000);
`endif

        // Reset after 3 of 8 beats aborts the window
        for (int i = 0; i < 3; i++) drive(1'b1, one_beam(3, 2, 0), 12'd8);
        @(posedge clk);
        #1;
        u_if.i_tvalid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst_rank_valid", 64'(u_if.o_rank_valid),  64'd0);
        check("rst_busy",       64'(u_if.o_busy),        64'd0);
        check("rst_overflow",   64'(u_if.o_overflow),    64'd0);
        check("rst_idx0",       64'(u_if.o_beam_idx[0]), 64'd0);
        check("rst_pwr0",       64'(u_if.o_beam_pwr[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = rv_cnt;
        repeat (100) @(posedge clk);
        check("rst_no_rank", 64'(rv_cnt), 64'(base));
        drive(1'b1, one_beam(7, 10, 0), 12'd1);
        drive(1'b0, '0, '0);
        wait_rank();
        base = rv_cnt - 1;
        check("post_rst_idx0", 64'(h_idx[base][0]), 64'd7);
        check("post_rst_pwr0", 64'(h_pwr[base][0]), 64'd100);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
